// File: rtl/display_scan_if.sv
// Bus between the BCD source, the scan controller and the 7-segment decoder.
interface display_scan_if;
    logic [15:0] data_in;
    logic        load;
    logic [15:0] number;
    logic [3:0]  dig;
    logic [3:0]  an_n;
    logic        pending;
    logic        frame_start;

    modport master (
        output data_in, load,
        input  number, dig, an_n, pending, frame_start
    );

    modport slave (
        input  data_in, load,
        output number, dig, an_n, pending, frame_start
    );
endinterface

// File: rtl/display_scan.sv
// 4-digit multiplexed display scan controller with double-buffered BCD value.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_LZB_EN.
module display_scan #(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    display_scan_if.slave   bus
);

    localparam int unsigned     CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]      DIG_FIRST = 4'b0001;
    localparam logic [3:0]      DIG_LAST  = 4'b1000;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dig_q, dig_d;
    logic [15:0]      number_q, number_d;
    logic [15:0]      shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             frame_start_q, frame_start_d;

    logic slot_end_c;
    logic frame_end_c;
    logic in_blank_c;
    logic [3:0] lzb_mask_c;
    logic [3:0] an_n_c;

    assign slot_end_c  = (cnt_q == CNT_LAST);
    assign frame_end_c = slot_end_c && (dig_q == DIG_LAST);

    // Next-state: slot counter, digit rotation, capture and frame transfer.
    always_comb begin
        cnt_d         = cnt_q + CNT_W'(1);
        dig_d         = dig_q;
        number_d      = number_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        frame_start_d = frame_end_c;

        if (slot_end_c) begin
            cnt_d = '0;
            dig_d = {dig_q[2:0], dig_q[3]};
        end

        if (bus.load) begin
            shadow_d  = bus.data_in;
            pending_d = 1'b1;
        end

        // New data arriving on the transfer edge bypasses the shadow.
        if (frame_end_c) begin
            if (bus.load) begin
                number_d  = bus.data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                number_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            dig_q         <= DIG_FIRST;
            number_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            number_q      <= number_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Anti-ghosting window at the start of each slot.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_blank_c = 1'b0;
        end else begin : g_blank
            assign in_blank_c = (cnt_q < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef DISPLAY_SCAN_LZB_EN
    assign lzb_mask_c = {(number_q[15:12] == 4'h0),
                         (number_q[15:8]  == 8'h00),
                         (number_q[15:4]  == 12'h000),
                         1'b0};
`else
    assign lzb_mask_c = 4'b0000;
`endif

    // Anodes are combinational so they track dig with no extra latency.
    assign an_n_c = (!rst_n || in_blank_c) ? 4'b1111 : (~dig_q | lzb_mask_c);

    assign bus.number      = number_q;
    assign bus.dig         = dig_q;
    assign bus.an_n        = an_n_c;
    assign bus.pending     = pending_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIV=8, BLANK_CYCLES=2.
module tb_display_scan;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;

    logic clk;
    logic rst_n;
    int   n;
    int   checks;
    int   errors;

    display_scan_if bus ();

    display_scan #(
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_dig(input int k);
        exp_dig = 4'(4'b0001 << ((k / DIV) % 4));
    endfunction

    function automatic logic [3:0] exp_an(input int k, input logic [15:0] num);
        logic [3:0] m;
        if ((k % DIV) < BLANK) return 4'b1111;
        m = ~exp_dig(k);
`ifdef DISPLAY_SCAN_LZB_EN
        if (num[15:4]  == 12'h000) m[1] = 1'b1;
        if (num[15:8]  == 8'h00)   m[2] = 1'b1;
        if (num[15:12] == 4'h0)    m[3] = 1'b1;
`endif
        return m;
    endfunction

    task automatic check_scan(input logic [15:0] num, input logic pend);
        check("dig",         32'(bus.dig),         32'(exp_dig(n)));
        check("an_n",        32'(bus.an_n),        32'(exp_an(n, num)));
        check("number",      32'(bus.number),      32'(num));
        check("pending",     32'(bus.pending),     32'(pend));
        check("frame_start", 32'(bus.frame_start), 32'((n % (4 * DIV) == 0) && (n > 0)));
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    task automatic run_to(input int target, input logic [15:0] num, input logic pend);
        while (n < target) begin
            tick();
            check_scan(num, pend);
        end
    endtask

    task automatic load_tick(input logic [15:0] data, input logic [15:0] num, input logic pend);
        bus.data_in = data;
        bus.load    = 1'b1;
        tick();
        bus.load    = 1'b0;
        check_scan(num, pend);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        n           = 0;
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst_dig",     32'(bus.dig),         32'h1);
        check("rst_an_n",    32'(bus.an_n),        32'hF);
        check("rst_number",  32'(bus.number),      32'h0);
        check("rst_pending", 32'(bus.pending),     32'h0);
        check("rst_fstart",  32'(bus.frame_start), 32'h0);

        rst_n = 1'b1;
        n     = 0;
        #1;
        check_scan(16'h0000, 1'b0);

        // Two full frames of scan timing, frame_start at 32 and 64.
        run_to(64, 16'h0000, 1'b0);

        // Deferred update: load during dig=0010, visible after the frame edge.
        run_to(72, 16'h0000, 1'b0);
        load_tick(16'h1234, 16'h0000, 1'b1);
        run_to(95, 16'h0000, 1'b1);
        run_to(96, 16'h1234, 1'b0);

        // Last load within a frame wins.
        run_to(100, 16'h1234, 1'b0);
        load_tick(16'h1111, 16'h1234, 1'b1);
        run_to(110, 16'h1234, 1'b1);
        load_tick(16'h5678, 16'h1234, 1'b1);
        run_to(127, 16'h1234, 1'b1);
        run_to(128, 16'h5678, 1'b0);

        // Load on the transfer edge overrides the pending value.
        run_to(130, 16'h5678, 1'b0);
        load_tick(16'hAAAA, 16'h5678, 1'b1);
        run_to(159, 16'h5678, 1'b1);
        load_tick(16'h9999, 16'h9999, 1'b0);

        // Asynchronous reset mid-slot with a value pending.
        run_to(170, 16'h9999, 1'b0);
        load_tick(16'h4321, 16'h9999, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dig",     32'(bus.dig),     32'h1);
        check("arst_an_n",    32'(bus.an_n),    32'hF);
        check("arst_number",  32'(bus.number),  32'h0);
        check("arst_pending", 32'(bus.pending), 32'h0);
        repeat (3) @(negedge clk);
        check("arst_hold_dig",  32'(bus.dig),  32'h1);
        check("arst_hold_an_n", 32'(bus.an_n), 32'hF);
        rst_n = 1'b1;
        n     = 0;
        #1;
        check_scan(16'h0000, 1'b0);
        run_to(40, 16'h0000, 1'b0);

        // Leading zeros and non-BCD nibbles.
        load_tick(16'h0042, 16'h0000, 1'b1);
        run_to(63, 16'h0000, 1'b1);
        run_to(96, 16'h0042, 1'b0);
        run_to(100, 16'h0042, 1'b0);
        load_tick(16'hA000, 16'h0042, 1'b1);
        run_to(127, 16'h0042, 1'b1);
        run_to(160, 16'hA000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
